// File: rtl/cpumc_loader.sv
// Byte-serial command loader in front of the CPU memory controller.
// Parses WRITE/READ/ECHO commands from the UART and drives the memory bus and tx FIFO.
module cpumc_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_full,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic [7:0]  mem_dout,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_wr,
    output logic        active
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_HDR     = 4'd1;
    localparam logic [3:0] S_WDATA   = 4'd2;
    localparam logic [3:0] S_WSTROBE = 4'd3;
    localparam logic [3:0] S_RADDR   = 4'd4;
    localparam logic [3:0] S_RWAIT   = 4'd5;
    localparam logic [3:0] S_RSEND   = 4'd6;
    localparam logic [3:0] S_ECHO    = 4'd7;
    localparam logic [3:0] S_ESEND   = 4'd8;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_ECHO  = 8'h03;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    logic [3:0]  state;
    logic [1:0]  hdr_idx;
    logic        is_read;
    logic [15:0] cnt;

    assign active = (state != S_IDLE);
    // tx pushes are gated combinationally so a full FIFO never sees a strobe
    assign tx_wr  = ((state == S_RSEND) || (state == S_ESEND)) && !tx_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            hdr_idx  <= 2'd0;
            is_read  <= 1'b0;
            cnt      <= 16'h0000;
            mem_addr <= 16'h0000;
            mem_din  <= 8'h00;
            mem_wr   <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        hdr_idx <= 2'd0;
                        case (rx_data)
                            OP_WRITE: begin
                                is_read <= 1'b0;
                                state   <= S_HDR;
                            end
                            OP_READ: begin
                                is_read <= 1'b1;
                                state   <= S_HDR;
                            end
                            OP_ECHO: state <= S_ECHO;
                            default: begin
                                tx_data <= ERR_BYTE;
                                state   <= S_ESEND;
                            end
                        endcase
                    end
                end
                S_HDR: begin
                    if (rx_valid) begin
                        hdr_idx <= hdr_idx + 2'd1;
                        case (hdr_idx)
                            2'd0: mem_addr[7:0]  <= rx_data;
                            2'd1: mem_addr[15:8] <= rx_data;
                            2'd2: cnt[7:0]       <= rx_data;
                            default: begin
                                cnt[15:8] <= rx_data;
                                if ({rx_data, cnt[7:0]} == 16'h0000)
                                    state <= S_IDLE;
                                else
                                    state <= is_read ? S_RADDR : S_WDATA;
                            end
                        endcase
                    end
                end
                S_WDATA: begin
                    if (rx_valid) begin
                        mem_din <= rx_data;
                        mem_wr  <= 1'b1;
                        cnt     <= cnt - 16'd1;
                        state   <= S_WSTROBE;
                    end
                end
                S_WSTROBE: begin
                    // Post-increment; a byte landing now gets its strobe at the new address next cycle
                    mem_addr <= mem_addr + 16'd1;
                    if (cnt == 16'h0000) begin
                        mem_wr <= 1'b0;
                        state  <= S_IDLE;
                    end else if (rx_valid) begin
                        mem_din <= rx_data;
                        mem_wr  <= 1'b1;
                        cnt     <= cnt - 16'd1;
                    end else begin
                        mem_wr <= 1'b0;
                        state  <= S_WDATA;
                    end
                end
                S_RADDR: state <= S_RWAIT;
                S_RWAIT: begin
                    tx_data <= mem_dout;
                    state   <= S_RSEND;
                end
                S_RSEND: begin
                    if (!tx_full) begin
                        cnt      <= cnt - 16'd1;
                        mem_addr <= mem_addr + 16'd1;
                        state    <= (cnt == 16'd1) ? S_IDLE : S_RADDR;
                    end
                end
                S_ECHO: begin
                    if (rx_valid) begin
                        tx_data <= rx_data;
                        state   <= S_ESEND;
                    end
                end
                S_ESEND: begin
                    if (!tx_full)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpumc_loader.sv
// Directed bench for cpumc_loader: scripted command streams, captured bus/tx events
// compared against a hand-computed expectation table.
module tb_cpumc_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_full;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic [7:0]  mem_dout;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_wr;
    logic        active;

    cpumc_loader dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_full(tx_full), .tx_data(tx_data), .tx_wr(tx_wr), .mem_dout(mem_dout),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr(mem_wr), .active(active)
    );

    always #10 clk = ~clk;

    // Memory model: returns address low byte, one-cycle read latency
    always @(posedge clk) mem_dout <= mem_addr[7:0];

    typedef struct {
        int          tst;
        bit          is_tx;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic [23:0] wq[$];
    logic [7:0]  txq[$];
    int          viol = 0;
    int          checks = 0;
    int          failures = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wr) wq.push_back({mem_addr, mem_din});
            if (tx_wr) txq.push_back(tx_data);
            if (tx_wr && tx_full) viol++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, ".mem_addr"}, 32'(mem_addr), 32'h0000);
        chk({name, ".mem_din"},  32'(mem_din),  32'h00);
        chk({name, ".mem_wr"},   32'(mem_wr),   32'h0);
        chk({name, ".tx_data"},  32'(tx_data),  32'h00);
        chk({name, ".tx_wr"},    32'(tx_wr),    32'h0);
        chk({name, ".active"},   32'(active),   32'h0);
    endtask

    exp_t tbl[$];

    task automatic check_test(input int t);
        logic [23:0] w;
        logic [7:0]  x;
        foreach (tbl[i]) begin
            if (tbl[i].tst == t) begin
                if (tbl[i].is_tx) begin
                    if (txq.size() == 0) chk($sformatf("t%0d.tx_missing", t), 32'h0, 32'h1);
                    else begin
                        x = txq.pop_front();
                        chk($sformatf("t%0d.tx", t), 32'(x), 32'(tbl[i].data));
                    end
                end else begin
                    if (wq.size() == 0) chk($sformatf("t%0d.wr_missing", t), 32'h0, 32'h1);
                    else begin
                        w = wq.pop_front();
                        chk($sformatf("t%0d.wr", t), 32'(w), {8'h00, tbl[i].addr, tbl[i].data});
                    end
                end
            end
        end
        chk($sformatf("t%0d.extra_wr", t), 32'(wq.size()), 32'd0);
        chk($sformatf("t%0d.extra_tx", t), 32'(txq.size()), 32'd0);
        wq.delete();
        txq.delete();
    endtask

    initial begin
        tbl = '{
            '{2, 1'b0, 16'hC000, 8'hAA}, '{2, 1'b0, 16'hC001, 8'hBB}, '{2, 1'b0, 16'hC002, 8'hCC},
            '{3, 1'b0, 16'hFFFF, 8'h11}, '{3, 1'b0, 16'h0000, 8'h22},
            '{4, 1'b1, 16'h0000, 8'h05}, '{4, 1'b1, 16'h0000, 8'h06},
            '{5, 1'b1, 16'h0000, 8'h5A}, '{5, 1'b1, 16'h0000, 8'hEE},
            '{6, 1'b0, 16'h2000, 8'hD1}, '{6, 1'b0, 16'h2001, 8'hD2},
            '{7, 1'b1, 16'h0000, 8'h3C}
        };

        // 1: reset with rx_valid and tx_full held high
        rst_n = 1'b0; rx_valid = 1'b1; rx_data = 8'h01; tx_full = 1'b1;
        #5;
        chk_reset_outputs("rst_async");
        idle(3);
        chk_reset_outputs("rst_held");
        rx_valid = 1'b0; tx_full = 1'b0;
        rst_n = 1'b1;
        idle(2);
        chk("rst_release.active", 32'(active), 32'h0);
        chk("rst_release.tx_wr", 32'(tx_wr), 32'h0);

        // 2: WRITE C000 x3, back-to-back payload
        send(8'h01); send(8'h00); send(8'hC0); send(8'h03); send(8'h00);
        send(8'hAA); send(8'hBB); send(8'hCC);
        @(negedge clk);
        chk("t2.last_strobe", 32'(mem_wr), 32'h1);
        chk("t2.active_during", 32'(active), 32'h1);
        @(negedge clk);
        chk("t2.active_fall", 32'(active), 32'h0);
        chk("t2.wr_fall", 32'(mem_wr), 32'h0);
        idle(2);
        check_test(2);

        // 3: WRITE wrap-around with a gap between payload bytes
        send(8'h01); send(8'hFF); send(8'hFF); send(8'h02); send(8'h00);
        send(8'h11); idle(2); send(8'h22);
        idle(3);
        check_test(3);

        // 4: READ 0005 x2 with tx_full held for 10 cycles
        tx_full = 1'b1;
        send(8'h02); send(8'h05); send(8'h00); send(8'h02); send(8'h00);
        idle(10);
        chk("t4.no_tx_while_full", 32'(txq.size()), 32'd0);
        chk("t4.active_stalled", 32'(active), 32'h1);
        tx_full = 1'b0;
        idle(10);
        chk("t4.active_done", 32'(active), 32'h0);
        check_test(4);

        // 5: READ CNT=0, ECHO 5A, bad opcode 7F
        send(8'h02); send(8'h34); send(8'h12); send(8'h00); send(8'h00);
        @(negedge clk);
        chk("t5.cnt0_idle", 32'(active), 32'h0);
        idle(1);
        send(8'h03); send(8'h5A);
        idle(3);
        send(8'h7F);
        idle(3);
        check_test(5);

        // 6: WRITE CNT=4 aborted by reset after the second data byte
        send(8'h01); send(8'h00); send(8'h20); send(8'h04); send(8'h00);
        send(8'hD1); send(8'hD2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6.abort");
        idle(2);
        chk("t6.no_more_wr", 32'(mem_wr), 32'h0);
        rst_n = 1'b1;
        idle(1);
        check_test(6);

        // 7: ECHO after the abort
        send(8'h03); send(8'h3C);
        idle(3);
        check_test(7);
        chk("tx_full_respected", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
